// File: rtl/top_level.sv
// top_level: single-cycle processor with 9-bit instructions and an 8-bit datapath.
// Holds the instruction ROM (instrMem1) and the data RAM (dataMemory) as named
// instances so their Core arrays can be preloaded by hierarchy.
// While start is high the core idles at PC 0. Once start falls it executes one
// instruction per cycle until HALT, then raises done and freezes.
// Optional feature: define TOP_LEVEL_CYCLE_CNT_EN to add a saturating 16-bit
// cycle_count output that counts execution cycles.
module top_level (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef TOP_LEVEL_CYCLE_CNT_EN
    output logic [15:0] cycle_count,
`endif
    output logic        done
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_LD  = 3'b011;
    localparam logic [2:0] OP_ST  = 3'b100;
    localparam logic [2:0] OP_LI  = 3'b101;
    localparam logic [2:0] OP_BR  = 3'b110;
    localparam logic [2:0] OP_EXT = 3'b111;

    localparam logic [2:0] FN_SHL     = 3'b000;
    localparam logic [2:0] FN_SHR     = 3'b001;
    localparam logic [2:0] FN_CMP     = 3'b010;
    localparam logic [2:0] FN_AND     = 3'b011;
    localparam logic [2:0] FN_MOVTO   = 3'b100;
    localparam logic [2:0] FN_MOVFROM = 3'b101;
    localparam logic [2:0] FN_NOP     = 3'b110;
    localparam logic [2:0] FN_HALT    = 3'b111;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t     state_reg;
    logic       done_reg;
    logic [7:0] pc_reg;
    logic [7:0] pc_next;
    logic       eq_reg, eq_next;
    logic       lt_reg, lt_next;

    logic [8:0] instr;
    logic [2:0] op, fa, fb;
    logic [7:0] rf [0:7];
    logic [7:0] ra_val, rb_val, r0_val;

    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       br_taken;
    logic       halt;
    logic       run;

    // Only execute when not held in restart and not already halted.
    assign run = !start && (state_reg == ST_RUN);

    instr_rom instrMem1 (
        .addr (pc_reg),
        .data (instr)
    );

    // Both LD and ST address memory through R[b]; ST writes R[a].
    data_ram dataMemory (
        .clk   (clk),
        .we    (run && mem_we),
        .addr  (rb_val),
        .wdata (ra_val),
        .rdata (mem_rdata)
    );

    assign op     = instr[8:6];
    assign fa     = instr[5:3];
    assign fb     = instr[2:0];
    assign ra_val = rf[fa];
    assign rb_val = rf[fb];
    assign r0_val = rf[0];

    // Register file: each register is its own flop bank, loaded only when it is
    // the destination of the executing instruction.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rf
            logic [7:0] val_reg;
            // Per-register load on a matching write address.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_reg <= 8'd0;
                end else if (run && rf_we && (rf_waddr == 3'(gi))) begin
                    val_reg <= rf_wdata;
                end
            end
            assign rf[gi] = val_reg;
        end
    endgenerate

    // Branch condition selected by the a field; codes 101-111 never branch.
    always_comb begin
        br_taken = 1'b0;
        case (fa)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = eq_reg;
            3'b010:  br_taken = !eq_reg;
            3'b011:  br_taken = lt_reg;
            3'b100:  br_taken = !lt_reg;
            default: br_taken = 1'b0;
        endcase
    end

    // Instruction decode: register write, memory write, flag and PC next values.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = fa;
        rf_wdata = ra_val;
        mem_we   = 1'b0;
        eq_next  = eq_reg;
        lt_next  = lt_reg;
        pc_next  = pc_reg + 8'd1;
        halt     = 1'b0;
        case (op)
            OP_ADD: begin
                rf_we    = 1'b1;
                rf_wdata = ra_val + rb_val;
            end
            OP_SUB: begin
                rf_we    = 1'b1;
                rf_wdata = ra_val - rb_val;
            end
            OP_XOR: begin
                rf_we    = 1'b1;
                rf_wdata = ra_val ^ rb_val;
            end
            OP_LD: begin
                rf_we    = 1'b1;
                rf_wdata = mem_rdata;
            end
            OP_ST: begin
                mem_we = 1'b1;
            end
            OP_LI: begin
                rf_we    = 1'b1;
                rf_waddr = 3'd0;
                rf_wdata = {2'b00, instr[5:0]};
            end
            OP_BR: begin
                if (br_taken) pc_next = rb_val;
            end
            default: begin
                // Extended group: fa is the function, fb names the register.
                rf_waddr = fb;
                case (fa)
                    FN_SHL: begin
                        rf_we    = 1'b1;
                        rf_wdata = {rb_val[6:0], 1'b0};
                    end
                    FN_SHR: begin
                        rf_we    = 1'b1;
                        rf_wdata = {1'b0, rb_val[7:1]};
                    end
                    FN_CMP: begin
                        eq_next = (rb_val == r0_val);
                        lt_next = (rb_val < r0_val);
                    end
                    FN_AND: begin
                        rf_we    = 1'b1;
                        rf_wdata = rb_val & r0_val;
                    end
                    FN_MOVTO: begin
                        rf_we    = 1'b1;
                        rf_wdata = r0_val;
                    end
                    FN_MOVFROM: begin
                        rf_we    = 1'b1;
                        rf_waddr = 3'd0;
                        rf_wdata = rb_val;
                    end
                    FN_NOP: begin
                        rf_we = 1'b0;
                    end
                    default: begin
                        halt    = 1'b1;
                        pc_next = pc_reg;
                    end
                endcase
            end
        endcase
    end

    // Run/halt control with PC, flags and the registered done output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            done_reg  <= 1'b0;
            pc_reg    <= 8'd0;
            eq_reg    <= 1'b0;
            lt_reg    <= 1'b0;
        end else if (start) begin
            state_reg <= ST_RUN;
            done_reg  <= 1'b0;
            pc_reg    <= 8'd0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    pc_reg <= pc_next;
                    eq_reg <= eq_next;
                    lt_reg <= lt_next;
                    if (halt) begin
                        state_reg <= ST_HALT;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_HALT;
                    done_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign done = done_reg;

`ifdef TOP_LEVEL_CYCLE_CNT_EN
    logic [15:0] cycle_count_reg;

    // Count executing cycles, cleared by restart, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_reg <= 16'd0;
        end else if (start) begin
            cycle_count_reg <= 16'd0;
        end else if ((state_reg == ST_RUN) && (cycle_count_reg != 16'hFFFF)) begin
            cycle_count_reg <= cycle_count_reg + 16'd1;
        end
    end

    assign cycle_count = cycle_count_reg;
`endif

endmodule

// instr_rom: 256x9 instruction store with combinational read. Contents are
// loaded from outside by hierarchy; there is no write port.
module instr_rom (
    input  logic [7:0] addr,
    output logic [8:0] data
);
    logic [8:0] Core [0:255];

    assign data = Core[addr];
endmodule

// data_ram: 256x8 data store, combinational read, write on the rising edge.
// Contents are not affected by reset.
module data_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] Core [0:255];

    assign rdata = Core[addr];

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            Core[addr] <= wdata;
        end
    end
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: directed tests for top_level. Each task loads a small program
// into instrMem1 by hierarchy, runs it and checks hand-computed results; the
// final task runs the min/max Hamming-distance program against a golden model.
module tb_top_level;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd2, OP_LD = 3'd3;
    localparam logic [2:0] OP_ST  = 3'd4, OP_BR  = 3'd6;
    localparam logic [2:0] F_SHL = 3'd0, F_SHR = 3'd1, F_CMP = 3'd2, F_AND = 3'd3;
    localparam logic [2:0] F_MOVTO = 3'd4, F_MOVFROM = 3'd5, F_NOP = 3'd6, F_HALT = 3'd7;
    localparam logic [2:0] C_AL = 3'd0, C_EQ = 3'd1, C_NE = 3'd2, C_LT = 3'd3;
    localparam logic [2:0] C_GE = 3'd4, C_NV = 3'd5;

    logic clk;
    logic rst_n;
    logic start;
    logic done;
`ifdef TOP_LEVEL_CYCLE_CNT_EN
    logic [15:0] cycle_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int ptr = 0;

    top_level dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef TOP_LEVEL_CYCLE_CNT_EN
        .cycle_count (cycle_count),
`endif
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] rr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
        return {op, a, b};
    endfunction

    function automatic logic [8:0] li(input logic [5:0] imm);
        return {3'b101, imm};
    endfunction

    function automatic logic [8:0] ex(input logic [2:0] f, input logic [2:0] r);
        return {3'b111, f, r};
    endfunction

    function automatic logic [8:0] br(input logic [2:0] c, input logic [2:0] r);
        return {OP_BR, c, r};
    endfunction

    // Hold the core in restart and begin writing a program at address 0.
    task automatic begin_load();
        @(negedge clk);
        start = 1'b1;
        ptr = 0;
    endtask

    task automatic put(input logic [8:0] w);
        dut.instrMem1.Core[ptr] = w;
        ptr++;
    endtask

    // Drop start and count rising edges until done, within a cycle budget.
    task automatic run_to_done(input int budget, output int cycles, output bit finished);
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        finished = 1'b0;
        for (int k = 0; k < budget && !finished; k++) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) finished = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (dut.pc_reg !== 8'd0) begin miscompares++; $display("FAIL reset_pc: got %0d want 0", dut.pc_reg); end
        for (int k = 0; k < 8; k++) begin
            vectors++; if (dut.rf[k] !== 8'd0) begin miscompares++; $display("FAIL reset_r%0d: got %0d want 0", k, dut.rf[k]); end
        end
        start = 1'b1;
        #1 rst_n = 1'b1;
        $display("reset: power-up reset applied");
    endtask

    task automatic test_store();
        int cyc; bit fin;
        begin_load();
        dut.dataMemory.Core[40] = 8'd0;
        put(li(6'd40)); put(ex(F_MOVTO, 3'd2)); put(li(6'd5)); put(rr(OP_ST, 3'd0, 3'd2)); put(ex(F_HALT, 3'd0));
        run_to_done(50, cyc, fin);
        vectors++; if (!fin) begin miscompares++; $display("FAIL store_timeout: done never rose within 50 cycles"); end
        vectors++; if (cyc != 5) begin miscompares++; $display("FAIL store_latency: got %0d edges want 5", cyc); end
        vectors++; if (dut.dataMemory.Core[40] !== 8'd5) begin miscompares++; $display("FAIL store_mem40: got %0d want 5", dut.dataMemory.Core[40]); end
        vectors++; if (dut.rf[2] !== 8'd40) begin miscompares++; $display("FAIL store_r2: got %0d want 40", dut.rf[2]); end
        repeat (3) @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL store_done_hold: got %b want 1", done); end
        vectors++; if (dut.pc_reg !== 8'd4) begin miscompares++; $display("FAIL store_pc_frozen: got %0d want 4", dut.pc_reg); end
        vectors++; if (dut.rf[0] !== 8'd5) begin miscompares++; $display("FAIL store_r0: got %0d want 5", dut.rf[0]); end
`ifdef TOP_LEVEL_CYCLE_CNT_EN
        vectors++; if (cycle_count !== 16'd5) begin miscompares++; $display("FAIL store_cycle_count: got %0d want 5", cycle_count); end
`endif
        $display("store: halted after %0d cycles, mem[40]=%0d", cyc, dut.dataMemory.Core[40]);
    endtask

    task automatic test_alu();
        int cyc; bit fin;
        begin_load();
        put(li(6'd45)); put(ex(F_MOVTO, 3'd4)); put(li(6'd15)); put(ex(F_MOVTO, 3'd5));
        put(rr(OP_XOR, 3'd4, 3'd5));
        put(ex(F_SHL, 3'd4)); put(ex(F_SHL, 3'd4)); put(ex(F_SHL, 3'd4));
        put(ex(F_SHR, 3'd5)); put(li(6'd60)); put(ex(F_AND, 3'd5));
        put(rr(OP_SUB, 3'd5, 3'd4)); put(ex(F_MOVFROM, 3'd5)); put(ex(F_NOP, 3'd0)); put(ex(F_HALT, 3'd0));
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL alu_start_clears_done: got %b want 0", done); end
        vectors++; if (dut.pc_reg !== 8'd0) begin miscompares++; $display("FAIL alu_start_pc: got %0d want 0", dut.pc_reg); end
        run_to_done(60, cyc, fin);
        vectors++; if (!fin) begin miscompares++; $display("FAIL alu_timeout: done never rose within 60 cycles"); end
        vectors++; if (cyc != 15) begin miscompares++; $display("FAIL alu_latency: got %0d edges want 15", cyc); end
        vectors++; if (dut.rf[4] !== 8'd16) begin miscompares++; $display("FAIL alu_r4_xor_shl: got %0d want 16", dut.rf[4]); end
        vectors++; if (dut.rf[5] !== 8'd244) begin miscompares++; $display("FAIL alu_r5_shr_and_sub: got %0d want 244", dut.rf[5]); end
        vectors++; if (dut.rf[0] !== 8'd244) begin miscompares++; $display("FAIL alu_r0_movfrom: got %0d want 244", dut.rf[0]); end
        vectors++; if (dut.pc_reg !== 8'd14) begin miscompares++; $display("FAIL alu_pc: got %0d want 14", dut.pc_reg); end
        $display("alu: halted after %0d cycles, r4=%0d r5=%0d", cyc, dut.rf[4], dut.rf[5]);
    endtask

    task automatic test_back_to_back();
        int cyc; bit fin;
        begin_load();
        dut.dataMemory.Core[50] = 8'd0;
        put(li(6'd50)); put(ex(F_MOVTO, 3'd2)); put(li(6'd33));
        put(rr(OP_ST, 3'd0, 3'd2)); put(rr(OP_LD, 3'd3, 3'd2)); put(ex(F_HALT, 3'd0));
        run_to_done(50, cyc, fin);
        vectors++; if (!fin) begin miscompares++; $display("FAIL b2b_timeout: done never rose within 50 cycles"); end
        vectors++; if (dut.rf[3] !== 8'd33) begin miscompares++; $display("FAIL b2b_load_after_store: got %0d want 33", dut.rf[3]); end
        vectors++; if (dut.dataMemory.Core[50] !== 8'd33) begin miscompares++; $display("FAIL b2b_mem50: got %0d want 33", dut.dataMemory.Core[50]); end
        $display("back_to_back: halted after %0d cycles, r3=%0d", cyc, dut.rf[3]);
    endtask

    task automatic test_flags();
        int cyc; bit fin;
        begin_load();
        put(li(6'd9)); put(ex(F_MOVTO, 3'd3)); put(li(6'd7)); put(ex(F_CMP, 3'd3)); put(ex(F_HALT, 3'd0));
        run_to_done(50, cyc, fin);
        vectors++; if (!fin) begin miscompares++; $display("FAIL flags_a_timeout: done never rose within 50 cycles"); end
        vectors++; if (dut.eq_reg !== 1'b0) begin miscompares++; $display("FAIL flags_a_eq: got %b want 0", dut.eq_reg); end
        vectors++; if (dut.lt_reg !== 1'b0) begin miscompares++; $display("FAIL flags_a_lt: got %b want 0", dut.lt_reg); end
        $display("flags: r3=9 vs r0=7 gives eq=%b lt=%b", dut.eq_reg, dut.lt_reg);
        // Swapped values, then three branches that must all fall through.
        begin_load();
        put(li(6'd7)); put(ex(F_MOVTO, 3'd3)); put(li(6'd9)); put(ex(F_CMP, 3'd3));
        put(li(6'd63)); put(br(C_NV, 3'd0)); put(br(C_EQ, 3'd0)); put(br(C_GE, 3'd0)); put(ex(F_HALT, 3'd0));
        run_to_done(50, cyc, fin);
        vectors++; if (!fin) begin miscompares++; $display("FAIL flags_b_timeout: done never rose within 50 cycles"); end
        vectors++; if (dut.lt_reg !== 1'b1) begin miscompares++; $display("FAIL flags_b_lt: got %b want 1", dut.lt_reg); end
        vectors++; if (dut.eq_reg !== 1'b0) begin miscompares++; $display("FAIL flags_b_eq: got %b want 0", dut.eq_reg); end
        vectors++; if (dut.pc_reg !== 8'd8) begin miscompares++; $display("FAIL flags_b_untaken_pc: got %0d want 8", dut.pc_reg); end
        vectors++; if (cyc != 9) begin miscompares++; $display("FAIL flags_b_latency: got %0d edges want 9", cyc); end
        $display("flags: r3=7 vs r0=9 gives eq=%b lt=%b, halted at pc %0d", dut.eq_reg, dut.lt_reg, dut.pc_reg);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL areset_done: got %b want 0", done); end
        vectors++; if (dut.pc_reg !== 8'd0) begin miscompares++; $display("FAIL areset_pc: got %0d want 0", dut.pc_reg); end
        vectors++; if (dut.lt_reg !== 1'b0) begin miscompares++; $display("FAIL areset_lt: got %b want 0", dut.lt_reg); end
        for (int k = 0; k < 8; k++) begin
            vectors++; if (dut.rf[k] !== 8'd0) begin miscompares++; $display("FAIL areset_r%0d: got %0d want 0", k, dut.rf[k]); end
        end
        start = 1'b1;
        #1 rst_n = 1'b1;
        $display("async_reset: state cleared without a clock edge");
    endtask

    task automatic load_countdown();
        begin_load();
        put(li(6'd3)); put(ex(F_MOVTO, 3'd1)); put(li(6'd1)); put(ex(F_MOVTO, 3'd6));
        put(li(6'd0)); put(ex(F_MOVTO, 3'd5)); put(li(6'd8)); put(ex(F_MOVTO, 3'd7));
        put(rr(OP_ADD, 3'd5, 3'd6)); put(rr(OP_SUB, 3'd1, 3'd6)); put(li(6'd0)); put(ex(F_CMP, 3'd1));
        put(br(C_NE, 3'd7)); put(ex(F_HALT, 3'd0));
    endtask

    task automatic test_branch_loop();
        int cyc; bit fin;
        load_countdown();
        run_to_done(100, cyc, fin);
        vectors++; if (!fin) begin miscompares++; $display("FAIL loop_timeout: done never rose within 100 cycles"); end
        vectors++; if (cyc != 24) begin miscompares++; $display("FAIL loop_latency: got %0d edges want 24", cyc); end
        vectors++; if (dut.rf[5] !== 8'd3) begin miscompares++; $display("FAIL loop_body_count: got %0d want 3", dut.rf[5]); end
        vectors++; if (dut.rf[1] !== 8'd0) begin miscompares++; $display("FAIL loop_r1: got %0d want 0", dut.rf[1]); end
        vectors++; if (dut.pc_reg !== 8'd13) begin miscompares++; $display("FAIL loop_pc: got %0d want 13", dut.pc_reg); end
        vectors++; if (dut.eq_reg !== 1'b1) begin miscompares++; $display("FAIL loop_eq: got %b want 1", dut.eq_reg); end
        $display("branch_loop: body ran %0d times in %0d cycles", dut.rf[5], cyc);
    endtask

    task automatic test_restart();
        int cyc; bit fin;
        load_countdown();
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL restart_midrun_done: got %b want 0", done); end
        start = 1'b1;
        @(negedge clk);
        vectors++; if (dut.pc_reg !== 8'd0) begin miscompares++; $display("FAIL restart_pc: got %0d want 0", dut.pc_reg); end
        @(negedge clk);
        vectors++; if (dut.pc_reg !== 8'd0) begin miscompares++; $display("FAIL restart_pc_held: got %0d want 0", dut.pc_reg); end
        run_to_done(100, cyc, fin);
        vectors++; if (!fin) begin miscompares++; $display("FAIL restart_timeout: done never rose within 100 cycles"); end
        vectors++; if (cyc != 24) begin miscompares++; $display("FAIL restart_latency: got %0d edges want 24", cyc); end
        vectors++; if (dut.rf[5] !== 8'd3) begin miscompares++; $display("FAIL restart_body_count: got %0d want 3", dut.rf[5]); end
        $display("restart: rerun from pc 0 halted after %0d cycles", cyc);
    endtask

    task automatic test_program1();
        int cyc; bit fin;
        logic [15:0] opnd [0:31];
        int gmin, gmax, d;
        begin_load();
        for (int k = 0; k < 32; k++) begin
            opnd[k] = 16'($urandom);
            dut.dataMemory.Core[2*k]   = opnd[k][15:8];
            dut.dataMemory.Core[2*k+1] = opnd[k][7:0];
        end
        gmin = 255; gmax = 0;
        for (int i = 0; i < 32; i++) begin
            for (int j = i + 1; j < 32; j++) begin
                d = $countones(opnd[i] ^ opnd[j]);
                if (d < gmin) gmin = d;
                if (d > gmax) gmax = d;
            end
        end
        // r6=1, mem[64]=255 (min), mem[65]=0 (max), r1=i byte address
        put(li(6'd1));          put(ex(F_MOVTO, 3'd6)); put(li(6'd63));         put(rr(OP_ADD, 3'd0, 3'd6));  //  0- 3
        put(ex(F_MOVTO, 3'd5)); put(li(6'd0));          put(rr(OP_SUB, 3'd0, 3'd6)); put(rr(OP_ST, 3'd0, 3'd5)); //  4- 7
        put(rr(OP_ADD, 3'd5, 3'd6)); put(li(6'd0));     put(rr(OP_ST, 3'd0, 3'd5)); put(li(6'd0));           //  8-11
        put(ex(F_MOVTO, 3'd1)); put(ex(F_MOVTO, 3'd3));                                                      // 12-13
        // outer (14): j = i + 2
        put(ex(F_MOVFROM, 3'd1)); put(rr(OP_ADD, 3'd0, 3'd6)); put(rr(OP_ADD, 3'd0, 3'd6)); put(ex(F_MOVTO, 3'd2)); // 14-17
        // inner (18): high byte xor, popcount loop A (top 27, exit 34)
        put(rr(OP_LD, 3'd4, 3'd1)); put(rr(OP_LD, 3'd5, 3'd2)); put(rr(OP_XOR, 3'd4, 3'd5));                 // 18-20
        put(li(6'd27)); put(ex(F_MOVTO, 3'd7)); put(li(6'd0)); put(ex(F_CMP, 3'd4)); put(li(6'd34)); put(br(C_EQ, 3'd0)); // 21-26
        put(ex(F_MOVFROM, 3'd4)); put(rr(OP_SUB, 3'd0, 3'd6)); put(ex(F_AND, 3'd4)); put(rr(OP_ADD, 3'd3, 3'd6)); // 27-30
        put(li(6'd0)); put(ex(F_CMP, 3'd4)); put(br(C_NE, 3'd7));                                            // 31-33
        // low byte xor, popcount loop B (top 47, exit 54)
        put(rr(OP_ADD, 3'd1, 3'd6)); put(rr(OP_ADD, 3'd2, 3'd6)); put(rr(OP_LD, 3'd4, 3'd1)); put(rr(OP_LD, 3'd5, 3'd2)); // 34-37
        put(rr(OP_XOR, 3'd4, 3'd5)); put(rr(OP_SUB, 3'd1, 3'd6)); put(rr(OP_SUB, 3'd2, 3'd6));               // 38-40
        put(li(6'd47)); put(ex(F_MOVTO, 3'd7)); put(li(6'd0)); put(ex(F_CMP, 3'd4)); put(li(6'd54)); put(br(C_EQ, 3'd0)); // 41-46
        put(ex(F_MOVFROM, 3'd4)); put(rr(OP_SUB, 3'd0, 3'd6)); put(ex(F_AND, 3'd4)); put(rr(OP_ADD, 3'd3, 3'd6)); // 47-50
        put(li(6'd0)); put(ex(F_CMP, 3'd4)); put(br(C_NE, 3'd7));                                            // 51-53
        // min update at mem[64]
        put(li(6'd63)); put(rr(OP_ADD, 3'd0, 3'd6)); put(ex(F_MOVTO, 3'd5)); put(rr(OP_LD, 3'd4, 3'd5));      // 54-57
        put(ex(F_MOVFROM, 3'd4)); put(ex(F_CMP, 3'd3)); put(li(6'd63)); put(br(C_GE, 3'd0)); put(rr(OP_ST, 3'd3, 3'd5)); // 58-62
        // max update at mem[65]; skip target 72 built as 36 << 1
        put(rr(OP_ADD, 3'd5, 3'd6)); put(rr(OP_LD, 3'd4, 3'd5)); put(ex(F_MOVFROM, 3'd4)); put(ex(F_CMP, 3'd3)); // 63-66
        put(li(6'd36)); put(ex(F_SHL, 3'd0)); put(br(C_LT, 3'd0)); put(br(C_EQ, 3'd0)); put(rr(OP_ST, 3'd3, 3'd5)); // 67-71
        // clear count, j += 2, loop while j != 64
        put(li(6'd0)); put(ex(F_MOVTO, 3'd3)); put(rr(OP_ADD, 3'd2, 3'd6)); put(rr(OP_ADD, 3'd2, 3'd6));      // 72-75
        put(li(6'd63)); put(rr(OP_ADD, 3'd0, 3'd6)); put(ex(F_CMP, 3'd2)); put(li(6'd18)); put(br(C_NE, 3'd0)); // 76-80
        // i += 2, loop while i != 62
        put(rr(OP_ADD, 3'd1, 3'd6)); put(rr(OP_ADD, 3'd1, 3'd6)); put(li(6'd62)); put(ex(F_CMP, 3'd1));       // 81-84
        put(li(6'd14)); put(br(C_NE, 3'd0)); put(ex(F_HALT, 3'd0));                                          // 85-87
        run_to_done(90000, cyc, fin);
        vectors++; if (!fin) begin miscompares++; $display("FAIL prog1_timeout: done never rose within 90000 cycles"); end
        vectors++; if (dut.dataMemory.Core[64] !== 8'(gmin)) begin miscompares++; $display("FAIL prog1_min: got %0d want %0d", dut.dataMemory.Core[64], gmin); end
        vectors++; if (dut.dataMemory.Core[65] !== 8'(gmax)) begin miscompares++; $display("FAIL prog1_max: got %0d want %0d", dut.dataMemory.Core[65], gmax); end
        vectors++; if (dut.pc_reg !== 8'd87) begin miscompares++; $display("FAIL prog1_halt_pc: got %0d want 87", dut.pc_reg); end
`ifdef TOP_LEVEL_CYCLE_CNT_EN
        vectors++; if (cycle_count !== 16'(cyc)) begin miscompares++; $display("FAIL prog1_cycle_count: got %0d want %0d", cycle_count, cyc); end
`endif
        $display("program1: %0d cycles, min=%0d max=%0d (model %0d/%0d)", cyc, dut.dataMemory.Core[64], dut.dataMemory.Core[65], gmin, gmax);
    endtask

    initial begin
        test_reset();
        test_store();
        test_alu();
        test_back_to_back();
        test_flags();
        test_async_reset();
        test_branch_loop();
        test_restart();
        test_program1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/top_level.md
# top_level

Single-cycle 9-bit-instruction, 8-bit-datapath processor used as the CSE141L program engine, e.g. min/max Hamming distance over 32 16-bit operands. It holds an instruction ROM and a data RAM as named submodules so a bench can preload them by hierarchy. It idles while `start` is high, runs from address 0 once `start` falls, and raises `done` on HALT.

## Interface
- No parameters. Fixed sizes: 256×9 instruction ROM, 256×8 data RAM, 8 registers r0–r7 of 8 bits, 8-bit PC.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  high = hold/restart; falling to low starts execution.
- done  output  1  high after HALT executes; reset value 0.
- Required hierarchy:
  - instance `instrMem1`, array `Core[0:255]`, 9 bits: asynchronous read, no write port.
  - instance `dataMemory`, array `Core[0:255]`, 8 bits: asynchronous read, synchronous write.
  - Neither memory is cleared by reset.

## Operation
- Instruction fields: op = [8:6], a = [5:3], b = [2:0]. Registers are named R[].
- Flags: EQ and LT. Only CMP writes them. Reset value 0.
- Opcodes:
  - 000 ADD: R[a] = R[a] + R[b], mod 256.
  - 001 SUB: R[a] = R[a] − R[b], mod 256.
  - 010 XOR: R[a] = R[a] ^ R[b].
  - 011 LD: R[a] = mem[R[b]].
  - 100 ST: mem[R[b]] = R[a].
  - 101 LI: r0 = zero-extended [5:0].
  - 110 BR: if condition a is true, PC = R[b]; otherwise PC+1.
    - a codes: 000 always, 001 EQ, 010 !EQ, 011 LT, 100 !LT.
    - 101–111 never taken.
  - 111 extended; funct = a, register = R[b]:
    - 000 SHL, 001 SHR (logical, 0 shifted in).
    - 010 CMP: EQ = (R[b] == r0), LT = (R[b] < r0), unsigned.
    - 011 AND: R[b] &= r0.
    - 100 MOVTO: R[b] = r0.
    - 101 MOVFROM: r0 = R[b].
    - 110 NOP.
    - 111 HALT.
- Non-branch instructions: PC = PC+1. PC wraps 255 → 0.
- The register file has no hardwired-zero register.

## Timing
- rst_n low (asynchronous): PC = 0, all registers 0, EQ = LT = 0, done = 0.
- start high at a clock edge:
  - PC ← 0, done ← 0.
  - No register, flag or memory write occurs.
  - This applies mid-run too: it aborts and restarts.
- start low, done low: exactly one instruction completes per cycle.
  - Register, flag, memory and PC updates all occur on the same edge.
  - Loads return data in the same cycle.
- HALT:
  - done ← 1 on that edge and PC stays at the HALT address.
  - done stays 1 and state is frozen until start goes high or rst_n goes low.
- A store followed by a load from the same address in the next cycle returns the stored value.
- A store to an address the same instruction reads reads the old value; only LD/ST access memory.

## Configuration
- TOP_LEVEL_CYCLE_CNT_EN defined:
  - Adds output `cycle_count`, 16 bits.
  - Cleared by reset and while start is high.
  - Increments each cycle that start is low and done is low; saturates at 0xFFFF.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: pulse rst_n low with start low → done = 0, PC = 0, r0–r7 = 0 immediately, without waiting for a clock edge.
- Store: ROM = LI 40; MOVTO r2; LI 5; ST r0,[r2]; HALT; start falls → dataMemory.Core[40] = 5 and done = 1 on the 5th edge after start falls.
- Branch loop: r1 counts down from 3 via SUB with a BR !EQ back to the loop top → body runs 3 times, then HALT; done = 1.
- Flags: r0 = 7, r3 = 9, CMP r3 → EQ = 0, LT = 0; swapping the values → LT = 1.
- Restart: assert start mid-run, then drop it → execution restarts from PC 0 and done stays 0 until HALT.
- Program 1: preload 32 random 16-bit operands into Core[0:63] with operand i = {Core[2i], Core[2i+1]}, load the program 1 machine code into the ROM → after done:
  - Core[64] = minimum pairwise Hamming distance.
  - Core[65] = maximum pairwise Hamming distance.
  - Both match the golden model.
